keypad_operand_entry: RTL

Front-end capture block for the hex divider. It scans the 4x4 keypad matrix by driving `col` and reading `fil`, then debounces and decodes each keypress into a 4-bit hex code. It assembles four keys into two 8-bit operands (A high nibble, A low, B high, B low) and issues a one-cycle `div_start` to the divider core. It then holds until `div_done` before accepting a new entry.

---
 rtl/keypad_operand_entry.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_operand_entry.sv
// Keypad front end for the hex divider: scans a 4x4 matrix, debounces presses,
// and assembles four hex keys into operands A and B before starting the divider.
module keypad_operand_entry #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] A_bin,
    output logic [7:0] B_bin,
    output logic       div_start,
    input  logic       div_done,
    output logic [2:0] entry_state
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_SCAN    = 2'd0;
    localparam logic [1:0] S_DEB     = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [2:0] E_A_HI  = 3'd0;
    localparam logic [2:0] E_A_LO  = 3'd1;
    localparam logic [2:0] E_B_HI  = 3'd2;
    localparam logic [2:0] E_B_LO  = 3'd3;
    localparam logic [2:0] E_START = 3'd4;
    localparam logic [2:0] E_WAIT  = 3'd5;

    logic [3:0]    r_sync1;
    logic [3:0]    r_fs;
    logic [1:0]    r_scan_state;
    logic [3:0]    r_col;
    logic [SW-1:0] r_div_cnt;
    logic [DW-1:0] r_db_cnt;
    logic [3:0]    r_latched;
    logic          r_key_valid;
    logic [3:0]    r_key_code;
    logic [2:0]    r_entry_state;
    logic [7:0]    r_a_bin;
    logic [7:0]    r_b_bin;
    logic          r_div_start;
    logic          w_fs_idle;

    // Index of the lowest zero bit; used for both the row and the one-hot-low column.
    function automatic logic [1:0] low_zero_idx(input logic [3:0] v);
        if (v[0] == 1'b0) begin
            return 2'd0;
        end else if (v[1] == 1'b0) begin
            return 2'd1;
        end else if (v[2] == 1'b0) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    assign w_fs_idle = (r_fs == 4'hF);

    // Two-flop synchronizer for the asynchronous keypad rows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 4'hF;
            r_fs    <= 4'hF;
        end else begin
            r_sync1 <= fil;
            r_fs    <= r_sync1;
        end
    end

    // Column scan, debounce and key decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_state <= S_SCAN;
            r_col        <= 4'b1110;
            r_div_cnt    <= '0;
            r_db_cnt     <= '0;
            r_latched    <= 4'hF;
            r_key_valid  <= 1'b0;
            r_key_code   <= 4'h0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_scan_state)
                S_SCAN: begin
                    if (!w_fs_idle) begin
                        r_latched    <= r_fs;
                        r_db_cnt     <= '0;
                        r_div_cnt    <= '0;
                        r_scan_state <= S_DEB;
                    end else if (r_div_cnt == SCAN_MAX) begin
                        r_div_cnt <= '0;
                        r_col     <= {r_col[2:0], r_col[3]};
                    end else begin
                        r_div_cnt <= r_div_cnt + SW'(1);
                    end
                end
                S_DEB: begin
                    if (w_fs_idle) begin
                        r_scan_state <= S_SCAN;
                    end else if (r_fs != r_latched) begin
                        r_latched <= r_fs;
                        r_db_cnt  <= '0;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_key_valid  <= 1'b1;
                        r_key_code   <= {low_zero_idx(r_latched), low_zero_idx(r_col)};
                        r_scan_state <= S_HELD;
                    end else begin
                        r_db_cnt <= r_db_cnt + DW'(1);
                    end
                end
                S_HELD: begin
                    if (w_fs_idle) begin
                        r_db_cnt     <= '0;
                        r_scan_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Scan resumes from the frozen column once release is stable.
                    if (!w_fs_idle) begin
                        r_scan_state <= S_HELD;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_div_cnt    <= '0;
                        r_scan_state <= S_SCAN;
                    end else begin
                        r_db_cnt <= r_db_cnt + DW'(1);
                    end
                end
                default: begin
                    r_scan_state <= S_SCAN;
                end
            endcase
        end
    end

    // Operand assembly and divider handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_entry_state <= E_A_HI;
            r_a_bin       <= 8'h00;
            r_b_bin       <= 8'h00;
            r_div_start   <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_entry_state)
                E_A_HI: begin
                    if (r_key_valid) begin
                        r_a_bin       <= {r_key_code, 4'h0};
                        r_entry_state <= E_A_LO;
                    end
                end
                E_A_LO: begin
                    if (r_key_valid) begin
                        r_a_bin[3:0]  <= r_key_code;
                        r_entry_state <= E_B_HI;
                    end
                end
                E_B_HI: begin
                    if (r_key_valid) begin
                        r_b_bin       <= {r_key_code, 4'h0};
                        r_entry_state <= E_B_LO;
                    end
                end
                E_B_LO: begin
                    if (r_key_valid) begin
                        r_b_bin[3:0]  <= r_key_code;
                        r_div_start   <= 1'b1;
                        r_entry_state <= E_START;
                    end
                end
                E_START: begin
                    r_entry_state <= E_WAIT;
                end
                E_WAIT: begin
                    // Keys arriving here, even alongside div_done, never touch the operands.
                    if (div_done) begin
                        r_entry_state <= E_A_HI;
                    end
                end
                default: begin
                    r_entry_state <= E_A_HI;
                end
            endcase
        end
    end

    assign col         = r_col;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign A_bin       = r_a_bin;
    assign B_bin       = r_b_bin;
    assign div_start   = r_div_start;
    assign entry_state = r_entry_state;

endmodule
